// File: rtl/operand_frame_serializer_if.sv
//------------------------------------------------------------------------------
// operand_frame_serializer_if : start/abort/operand inputs and serial frame outputs
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface operand_frame_serializer_if #(
  parameter int W = 4
);
  logic         start;
  logic         abort;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         shift_en;
  logic         sdata;
  logic         busy;
  logic         done;

  modport master (
    output start, abort, a, b,
    input  shift_en, sdata, busy, done
  );

  modport slave (
    input  start, abort, a, b,
    output shift_en, sdata, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/operand_frame_serializer.sv
//------------------------------------------------------------------------------
// operand_frame_serializer : frames A, GAP zeros, B, TAIL zeros LSB-first.
// Option macro SERIALIZER_PARITY_EN appends an even-parity bit after TAIL.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module operand_frame_serializer #(
  parameter int W    = 4,
  parameter int GAP  = 4,
  parameter int TAIL = 8
) (
  input  wire logic                  clk,
  input  wire logic                  clr,
  operand_frame_serializer_if.slave  sif
);

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int F  = 2*W + GAP + TAIL + PAR_BITS;
  localparam int CW = $clog2(F+1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_count, w_count;
  logic [W-1:0]    r_a, w_a;
  logic [W-1:0]    r_b, w_b;
  logic            r_shift_en, w_shift_en;
  logic            r_sdata, w_sdata;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic [F-1:0]    w_frame;
  logic            w_bit;

  // Whole frame laid out from the captured operands; count selects the bit.
  always_comb begin
    w_frame               = '0;
    w_frame[W-1:0]        = r_a;
    w_frame[W+GAP +: W]   = r_b;
`ifdef SERIALIZER_PARITY_EN
    w_frame[F-1]          = ^{r_a, r_b};
`endif
    w_bit = 1'b0;
    for (int i = 0; i < F; i++) begin
      if (r_count == CW'(i)) w_bit = w_frame[i];
    end
  end

  always_comb begin
    w_state    = r_state;
    w_count    = r_count;
    w_a        = r_a;
    w_b        = r_b;
    w_shift_en = r_shift_en;
    w_sdata    = r_sdata;
    w_busy     = r_busy;
    w_done     = r_done;
    case (r_state)
      S_IDLE: begin
        w_shift_en = 1'b0;
        w_sdata    = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_count    = '0;
        // abort outranks start so a cancelled request never launches a frame
        if (sif.start && !sif.abort) begin
          w_a        = sif.a;
          w_b        = sif.b;
          w_count    = CW'(1);
          w_shift_en = 1'b1;
          w_sdata    = sif.a[0];
          w_busy     = 1'b1;
          w_state    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sif.abort) begin
          w_shift_en = 1'b0;
          w_sdata    = 1'b0;
          w_count    = '0;
          w_busy     = 1'b0;
          w_state    = S_IDLE;
        end else if (r_count < CW'(F)) begin
          w_sdata = w_bit;
          w_count = r_count + CW'(1);
        end else begin
          w_shift_en = 1'b0;
          w_sdata    = 1'b0;
          w_done     = 1'b1;
          w_state    = S_DONE;
        end
      end
      S_DONE: begin
        w_done  = 1'b0;
        w_busy  = 1'b0;
        w_count = '0;
        w_state = S_IDLE;
      end
      default: begin
        w_shift_en = 1'b0;
        w_sdata    = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_count    = '0;
        w_state    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_shift_en <= 1'b0;
      r_sdata    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_count    <= w_count;
      r_a        <= w_a;
      r_b        <= w_b;
      r_shift_en <= w_shift_en;
      r_sdata    <= w_sdata;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign sif.shift_en = r_shift_en;
  assign sif.sdata    = r_sdata;
  assign sif.busy     = r_busy;
  assign sif.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_operand_frame_serializer.sv
//------------------------------------------------------------------------------
// tb_operand_frame_serializer : directed bench for default and W=8/GAP=0/TAIL=2
// builds, parity-aware when SERIALIZER_PARITY_EN is defined.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_operand_frame_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk;
  logic       clr;
  logic       dsel;
  logic       start;
  logic       abort;
  logic [7:0] a;
  logic [7:0] b;
  int         n_cmp;
  int         n_err;

  operand_frame_serializer_if #(.W(4)) if0 ();
  operand_frame_serializer_if #(.W(8)) if1 ();

  assign if0.start = start & ~dsel;
  assign if0.abort = abort & ~dsel;
  assign if0.a     = a[3:0];
  assign if0.b     = b[3:0];
  assign if1.start = start & dsel;
  assign if1.abort = abort & dsel;
  assign if1.a     = a;
  assign if1.b     = b;

  operand_frame_serializer #(.W(4), .GAP(4), .TAIL(8)) u_dut0 (
    .clk (clk),
    .clr (clr),
    .sif (if0)
  );

  operand_frame_serializer #(.W(8), .GAP(0), .TAIL(2)) u_dut1 (
    .clk (clk),
    .clr (clr),
    .sif (if1)
  );

  wire w_sh   = dsel ? if1.shift_en : if0.shift_en;
  wire w_sd   = dsel ? if1.sdata    : if0.sdata;
  wire w_busy = dsel ? if1.busy     : if0.busy;
  wire w_done = dsel ? if1.done     : if0.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input int i, input int w, input int gap, input int tail,
                                   input logic [7:0] ea, input logic [7:0] eb);
    if (i < w)                                   return ea[i];
    else if (i < w + gap)                        return 1'b0;
    else if (i < 2*w + gap)                      return eb[i-w-gap];
    else if (PAR == 1 && i == 2*w + gap + tail)  return ^(ea ^ eb);
    else                                         return 1'b0;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_sh"},   {31'd0, w_sh},   32'd0);
    chk({tag, "_sd"},   {31'd0, w_sd},   32'd0);
    chk({tag, "_busy"}, {31'd0, w_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, w_done}, 32'd0);
  endtask

  // Entered #1 after the start edge; returns #1 after the DONE->IDLE edge.
  task automatic expect_frame(input string tag, input int w, input int gap, input int tail,
                              input logic [7:0] ea, input logic [7:0] eb, input bit disturb);
    int f;
    f = 2*w + gap + tail + PAR;
    for (int i = 0; i < f; i++) begin
      if (disturb) begin
        if (i == 0) begin
          a = 8'h0F;
          b = 8'h0F;
        end
        start = (i == 5);
      end
      chk($sformatf("%s_sh%0d", tag, i),   {31'd0, w_sh},   32'd1);
      chk($sformatf("%s_bit%0d", tag, i),  {31'd0, w_sd},   {31'd0, exp_bit(i, w, gap, tail, ea, eb)});
      chk($sformatf("%s_busy%0d", tag, i), {31'd0, w_busy}, 32'd1);
      chk($sformatf("%s_dn%0d", tag, i),   {31'd0, w_done}, 32'd0);
      tick();
    end
    chk({tag, "_end_sh"},   {31'd0, w_sh},   32'd0);
    chk({tag, "_end_sd"},   {31'd0, w_sd},   32'd0);
    chk({tag, "_end_done"}, {31'd0, w_done}, 32'd1);
    chk({tag, "_end_busy"}, {31'd0, w_busy}, 32'd1);
    if (disturb) start = 1'b1;
    tick();
    if (disturb) start = 1'b0;
    chk({tag, "_post_done"}, {31'd0, w_done}, 32'd0);
    chk({tag, "_post_busy"}, {31'd0, w_busy}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    dsel  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    clr   = 1'b0;
    #12;
    check_idle("rst0");
    dsel = 1'b1;
    #1;
    check_idle("rst1");
    dsel = 1'b0;
    clr  = 1'b1;
    tick();

    // basic frame
    a = 8'h0B; b = 8'h06; start = 1'b1;
    tick();
    start = 1'b0;
    expect_frame("basic", 4, 4, 8, 8'h0B, 8'h06, 1'b0);

    // operand change after capture plus start while busy
    a = 8'h0B; b = 8'h06; start = 1'b1;
    tick();
    start = 1'b0;
    expect_frame("hold", 4, 4, 8, 8'h0B, 8'h06, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("noqueue%0d", k), {31'd0, w_busy}, 32'd0);
    end

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_idle("startabort");

    // abort during frame bit 7
    a = 8'h0B; b = 8'h06; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("abort_pre_bit7", {31'd0, w_sd}, {31'd0, exp_bit(7, 4, 4, 8, 8'h0B, 8'h06)});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort");
    for (int k = 0; k < 25; k++) begin
      tick();
      chk($sformatf("abort_nodone%0d", k), {31'd0, w_done}, 32'd0);
    end
    a = 8'h0B; b = 8'h06; start = 1'b1;
    tick();
    start = 1'b0;
    expect_frame("after_abort", 4, 4, 8, 8'h0B, 8'h06, 1'b0);

    // asynchronous clear mid-frame
    a = 8'h0B; b = 8'h06; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("clr_pre_busy", {31'd0, w_busy}, 32'd1);
    #2;
    clr = 1'b0;
    #1;
    check_idle("clr_async");
    #1;
    clr = 1'b1;
    tick();
    check_idle("clr_release");
    a = 8'h0B; b = 8'h06; start = 1'b1;
    tick();
    start = 1'b0;
    expect_frame("after_clr", 4, 4, 8, 8'h0B, 8'h06, 1'b0);

    // wide configuration, start held for back-to-back frames
    dsel = 1'b1;
    tick();
    check_idle("w8_idle");
    a = 8'hA5; b = 8'h3C; start = 1'b1;
    tick();
    a = 8'h00; b = 8'h00;
    expect_frame("w8_f1", 8, 0, 2, 8'hA5, 8'h3C, 1'b0);
    a = 8'h5A; b = 8'hC3;
    tick();
    start = 1'b0;
    expect_frame("w8_f2", 8, 0, 2, 8'h5A, 8'hC3, 1'b0);
    tick();
    check_idle("w8_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
